inv_permute_slices: RTL

//  Inverse of the 25-bit slice permutation stage (pi^-1) for the 64-slice state memory.

---
 rtl/inv_permute_slices_pkg.sv | 29 ++
 rtl/inv_permute_slices_inv_pi.sv | 16 +
 rtl/inv_permute_slices.sv | 112 +++++++++++
 3 files changed

// File: rtl/inv_permute_slices_pkg.sv
// Shared definitions for the slice permutation stages (forward and inverse).
// Holds the slice geometry defaults, the controller state type and the
// forward lane map pi_fwd_idx(). Both directions use this one definition of
// the map, so they cannot drift apart.
package inv_permute_slices_pkg;

    localparam int unsigned SLICE_W    = 25;
    localparam int unsigned DEF_SLICES = 64;
    localparam int unsigned DEF_ADR_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_e;

    // Forward lane map. Lane i sits at x = i%5, y = i/5 after a (+3,+3)
    // coordinate shift; result is a lane index in [0:24] (index 0 = MSB).
    function automatic int unsigned pi_fwd_idx(input int unsigned i);
        int unsigned x;
        int unsigned y;
        x = ((i % 5) + 3) % 5;
        y = ((i / 5) + 3) % 5;
        return ((y + 2) % 5) + 5 * ((((2 * x + 3 * y) % 5) + 2) % 5);
    endfunction

endpackage

// File: rtl/inv_permute_slices_inv_pi.sv
// inv_pi_slice: purely combinational inverse lane permutation of one slice.
//   slice_i : input slice  [0:24], index 0 is MSB
//   slice_o : output slice [0:24], slice_o[i] = slice_i[pi_fwd_idx(i)]
// Pure wiring; the index function is evaluated at elaboration time.
module inv_pi_slice
    import inv_permute_slices_pkg::*;
(
    input  logic [0:SLICE_W-1] slice_i,
    output logic [0:SLICE_W-1] slice_o
);

    for (genvar i = 0; i < SLICE_W; i++) begin : g_lane
        assign slice_o[i] = slice_i[pi_fwd_idx(i)];
    end

endmodule

// File: rtl/inv_permute_slices.sv
// inv_permute_slices: walks slices 0..SLICES-1 of the single-port slice
// memory, reading each slice, applying the inverse lane permutation and
// writing it back in place. Each slice costs 2+RD_LAT cycles.
//   clock     : rising-edge clock
//   reset     : asynchronous, active-low reset
//   start     : level run request, sampled only in IDLE/DONE
//   mem_rdata : slice read data, valid RD_LAT cycles after the read cycle
//   mem_adr   : slice address, held from the read through the write
//   mem_r     : read strobe, one cycle per slice
//   mem_w     : write strobe, one cycle per slice
//   mem_wdata : permuted slice, valid while mem_w=1
//   busy      : high in every state except IDLE/DONE
//   done      : high while in DONE
module inv_permute_slices
    import inv_permute_slices_pkg::*;
#(
    parameter int unsigned SLICES = DEF_SLICES,
    parameter int unsigned ADR_W  = DEF_ADR_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [0:SLICE_W-1] mem_rdata,
    output logic [ADR_W-1:0]   mem_adr,
    output logic               mem_r,
    output logic               mem_w,
    output logic [0:SLICE_W-1] mem_wdata,
    output logic               busy,
    output logic               done
);

    // One extra counter bit keeps the terminal compare from wrapping.
    localparam int unsigned      CNT_W    = ADR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICES - 1);
    localparam logic [1:0]       LAT_LAST = 2'(RD_LAT - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         lat_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic [0:SLICE_W-1] perm_d;

    assign cnt_inc = cnt_q + 1'b1;

    inv_pi_slice u_inv_pi (
        .slice_i (mem_rdata),
        .slice_o (perm_d)
    );

    // Outputs are registered alongside the state: each transition sets the
    // strobes and flags that belong to the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            lat_q     <= '0;
            mem_adr   <= '0;
            mem_r     <= 1'b0;
            mem_w     <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_r <= 1'b0;
            mem_w <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_READ;
                        cnt_q   <= '0;
                        mem_adr <= '0;
                        mem_r   <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                ST_READ: begin
                    state_q <= ST_WAIT;
                    lat_q   <= '0;
                end
                ST_WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        mem_wdata <= perm_d;
                        mem_w     <= 1'b1;
                        state_q   <= ST_WRITE;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                ST_WRITE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_inc;
                        mem_adr <= cnt_inc[ADR_W-1:0];
                        mem_r   <= 1'b1;
                        state_q <= ST_READ;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
